// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner
// Front end of the I2C EEPROM slave. Each raw pad line goes through a
// 2-flop synchroniser and a glitch filter. The filtered levels are then
// turned into single-cycle event pulses for the downstream bit/byte FSM.
// The block also tracks whether the bus is busy and aborts a stalled
// transfer with a timeout pulse.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset (idle bus state)
//   scl_in     raw SCL from pad
//   sda_in     raw SDA from pad
//   scl_f      filtered SCL level
//   sda_f      filtered SDA level
//   scl_rise   1-cycle pulse on filtered SCL 0->1
//   scl_fall   1-cycle pulse on filtered SCL 1->0
//   start      1-cycle pulse on START, including repeated START
//   rep_start  1-cycle pulse alongside start when the bus was already busy
//   stop       1-cycle pulse on STOP
//   bus_busy   high between START and STOP/timeout
//   timeout    1-cycle pulse when a busy bus sees no SCL edge for too long
module i2c_line_conditioner #(
  parameter int FILTER_LEN     = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic rep_start,
  output logic stop,
  output logic bus_busy,
  output logic timeout
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {BUS_IDLE, BUS_BUSY} bus_state_t;

  logic           scl_s1, scl_s2, sda_s1, sda_s2;
  logic [FCW-1:0] scl_cnt, sda_cnt;
  logic           scl_f_prev, sda_f_prev;
  logic           scl_edge, start_det, stop_det;
  bus_state_t     bus_state, bus_next;
  logic [TCW-1:0] to_cnt, to_cnt_next;
  logic           timeout_next, rep_start_next;

  // Two-flop synchronisers. They reset high so that an idle bus stays
  // quiet when reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
    end
  end

  // SCL glitch filter: the synchronised level must disagree with the
  // filtered level for FILTER_LEN consecutive clocks before it is taken.
  // A single agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_f   <= 1'b1;
      scl_cnt <= '0;
    end else if (scl_s2 != scl_f) begin
      if (scl_cnt == F_LAST) begin
        scl_f   <= scl_s2;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + FCW'(1);
      end
    end else begin
      scl_cnt <= '0;
    end
  end

  // SDA glitch filter, identical in behaviour to the SCL one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_f   <= 1'b1;
      sda_cnt <= '0;
    end else if (sda_s2 != sda_f) begin
      if (sda_cnt == F_LAST) begin
        sda_f   <= sda_s2;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + FCW'(1);
      end
    end else begin
      sda_cnt <= '0;
    end
  end

  // START/STOP need SCL high in both samples. That requirement also
  // suppresses them when SCL and SDA move in the same cycle, so only the
  // SCL edge is reported in that case.
  assign scl_edge  = scl_f ^ scl_f_prev;
  assign start_det = scl_f & scl_f_prev & sda_f_prev & ~sda_f;
  assign stop_det  = scl_f & scl_f_prev & ~sda_f_prev & sda_f;

  // Bus state and timeout counter, next-state logic.
  // Priority while busy: a START keeps the bus busy, then a STOP frees it,
  // then any SCL edge restarts the stall count. Only when none of these
  // happens does the counter advance. A STOP on the terminal count
  // therefore frees the bus without raising a timeout.
  always_comb begin
    bus_next       = bus_state;
    to_cnt_next    = '0;
    timeout_next   = 1'b0;
    rep_start_next = 1'b0;
    case (bus_state)
      BUS_IDLE: begin
        if (start_det) bus_next = BUS_BUSY;
      end
      BUS_BUSY: begin
        if (start_det) begin
          rep_start_next = 1'b1;
        end else if (stop_det) begin
          bus_next = BUS_IDLE;
        end else if (!scl_edge) begin
          if (to_cnt == T_LAST) begin
            bus_next     = BUS_IDLE;
            timeout_next = 1'b1;
          end else begin
            to_cnt_next = to_cnt + TCW'(1);
          end
        end
      end
      default: bus_next = BUS_IDLE;
    endcase
  end

  // Registered events, bus state, and the previous filtered levels that
  // the edge detection compares against.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_state  <= BUS_IDLE;
      to_cnt     <= '0;
      scl_f_prev <= 1'b1;
      sda_f_prev <= 1'b1;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start      <= 1'b0;
      rep_start  <= 1'b0;
      stop       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      bus_state  <= bus_next;
      to_cnt     <= to_cnt_next;
      scl_f_prev <= scl_f;
      sda_f_prev <= sda_f;
      scl_rise   <= scl_f & ~scl_f_prev;
      scl_fall   <= ~scl_f & scl_f_prev;
      start      <= start_det;
      rep_start  <= rep_start_next;
      stop       <= stop_det;
      timeout    <= timeout_next;
    end
  end

  assign bus_busy = (bus_state == BUS_BUSY);

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// tb_i2c_line_conditioner
// Directed bench for i2c_line_conditioner, built around a scoreboard.
// Each stimulus step queues the event it should cause: the cycle it should
// appear in, the pulse pattern, and bus_busy at that time. A separate
// monitor pops one entry whenever any event pulse is high and compares the
// two. Quiet stretches are covered because any event nobody expected is
// reported as a failure.
module tb_i2c_line_conditioner;

  localparam int FILTER_LEN     = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int LAT            = FILTER_LEN + 3;

  // Event vector bit positions: {timeout, stop, rep_start, start, fall, rise}
  localparam logic [5:0] EV_RISE  = 6'b000001;
  localparam logic [5:0] EV_FALL  = 6'b000010;
  localparam logic [5:0] EV_START = 6'b000100;
  localparam logic [5:0] EV_REP   = 6'b001000;
  localparam logic [5:0] EV_STOP  = 6'b010000;
  localparam logic [5:0] EV_TO    = 6'b100000;

  typedef struct {
    int         cyc;
    logic [5:0] ev;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset, scl_in, sda_in;
  logic scl_f, sda_f, scl_rise, scl_fall, start, rep_start, stop, bus_busy, timeout;
  logic [5:0] ev_now;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  i2c_line_conditioner #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_f    (scl_f),
    .sda_f    (sda_f),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .rep_start(rep_start),
    .stop     (stop),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  assign ev_now = {timeout, stop, rep_start, start, scl_fall, scl_rise};

  always #5 clk = ~clk;

  // Cycle index, advanced on every rising edge.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic scl, input logic sda);
    scl_in = scl;
    sda_in = sda;
  endtask

  task automatic expectEvent(input int delay, input logic [5:0] ev, input logic busy);
    exp_t e;
    e.cyc  = cyc + delay;
    e.ev   = ev;
    e.busy = busy;
    exp_q.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (ev_now != 6'b0)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_event: got events %b at cycle %0d, expected none", ev_now, cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_cycle", cyc, e.cyc);
        checkOutput("event_pulses", int'(ev_now), int'(e.ev));
        checkOutput("event_busy", int'(bus_busy), int'(e.busy));
      end
    end
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1);
    step(3);
    checkOutput("reset_lines", int'({scl_f, sda_f, bus_busy}), 3'b110);
    checkOutput("reset_pulses", int'(ev_now), 0);
    reset = 1'b0;
    step(20);
    checkOutput("idle_lines", int'({scl_f, sda_f, bus_busy}), 3'b110);

    // START, then a clock pulse, SDA high during SCL low, then a repeated START.
    applyStimulus(1'b1, 1'b0); expectEvent(LAT, EV_START, 1'b1); step(8);
    checkOutput("started_lines", int'({scl_f, sda_f, bus_busy}), 3'b101);
    applyStimulus(1'b0, 1'b0); expectEvent(LAT, EV_FALL, 1'b1); step(8);
    applyStimulus(1'b0, 1'b1); step(4);
    applyStimulus(1'b1, 1'b1); expectEvent(LAT, EV_RISE, 1'b1); step(8);
    applyStimulus(1'b1, 1'b0); expectEvent(LAT, EV_START | EV_REP, 1'b1); step(8);

    // SCL and SDA move together: only the SCL edge is reported.
    applyStimulus(1'b0, 1'b1); expectEvent(LAT, EV_FALL, 1'b1); step(8);
    checkOutput("simultaneous_lines", int'({scl_f, sda_f, bus_busy}), 3'b011);
    applyStimulus(1'b1, 1'b1); expectEvent(LAT, EV_RISE, 1'b1); step(8);
    applyStimulus(1'b1, 1'b0); expectEvent(LAT, EV_START | EV_REP, 1'b1); step(8);
    applyStimulus(1'b1, 1'b1); expectEvent(LAT, EV_STOP, 1'b0); step(20);
    checkOutput("stopped_lines", int'({scl_f, sda_f, bus_busy}), 3'b110);

    // 2-clock SDA glitch is rejected; a 3-clock one is a START then a STOP.
    applyStimulus(1'b1, 1'b0); step(2);
    applyStimulus(1'b1, 1'b1); step(10);
    checkOutput("glitch2_lines", int'({scl_f, sda_f, bus_busy}), 3'b110);
    applyStimulus(1'b1, 1'b0);
    expectEvent(LAT, EV_START, 1'b1);
    expectEvent(LAT + 3, EV_STOP, 1'b0);
    step(3);
    applyStimulus(1'b1, 1'b1); step(12);

    // Stall with SCL low: timeout 16 clocks after the scl_fall pulse.
    applyStimulus(1'b1, 1'b0); expectEvent(LAT, EV_START, 1'b1); step(8);
    applyStimulus(1'b0, 1'b0);
    expectEvent(LAT, EV_FALL, 1'b1);
    expectEvent(LAT + TIMEOUT_CYCLES, EV_TO, 1'b0);
    step(30);
    checkOutput("timeout_lines", int'({scl_f, sda_f, bus_busy}), 3'b000);
    // A later SCL edge gives no timeout; a STOP on an idle bus still pulses.
    applyStimulus(1'b1, 1'b0); expectEvent(LAT, EV_RISE, 1'b0); step(10);
    applyStimulus(1'b1, 1'b1); expectEvent(LAT, EV_STOP, 1'b0); step(10);

    // Asynchronous reset in the middle of a transfer with SDA low.
    applyStimulus(1'b1, 1'b0); expectEvent(LAT, EV_START, 1'b1); step(8);
    applyStimulus(1'b0, 1'b0); expectEvent(LAT, EV_FALL, 1'b1); step(8);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_lines", int'({scl_f, sda_f, bus_busy}), 3'b110);
    checkOutput("async_reset_pulses", int'(ev_now), 0);
    applyStimulus(1'b1, 1'b1);
    step(4);
    reset = 1'b0;
    step(20);
    checkOutput("post_reset_lines", int'({scl_f, sda_f, bus_busy}), 3'b110);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
